// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the multi-channel clock divider.
package clk_div_pkg;

    localparam int unsigned DEF_NUM_CH  = 4;
    localparam int unsigned DEF_RATIO_W = 8;
    localparam int unsigned MIN_RATIO   = 2;

    typedef logic [DEF_RATIO_W-1:0] ratio_t;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_RUN  = 1'b1
    } ch_state_e;

    // Number of high cycles in a period of r source cycles (ceil(r/2)).
    function automatic int unsigned hi_cnt(int unsigned r);
        return (r + 1) >> 1;
    endfunction

endpackage

// File: rtl/clk_div_multi_if.sv
// Control and output bundle of clk_div_multi; master drives, divider is slave.
interface clk_div_multi_if
    import clk_div_pkg::*;
#(
    parameter int unsigned NUM_CH  = DEF_NUM_CH,
    parameter int unsigned RATIO_W = DEF_RATIO_W
);

    logic [NUM_CH-1:0]         i_en;
    logic [NUM_CH-1:0]         i_load;
    logic [NUM_CH*RATIO_W-1:0] i_ratio;
    logic [NUM_CH-1:0]         o_clk;
    logic [NUM_CH-1:0]         o_tick;

    modport master (
        output i_en, i_load, i_ratio,
        input  o_clk, o_tick
    );

    modport slave (
        input  i_en, i_load, i_ratio,
        output o_clk, o_tick
    );

endinterface

// File: rtl/clk_div_ch.sv
// One divider channel: shadow ratio, period counter, IDLE/RUN FSM.
// Optional CLK_DIV_DUTY_50_EN adds a falling-edge flop for exact 50% duty on odd ratios.
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int unsigned RATIO_W = DEF_RATIO_W
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_en,
    input  logic               i_load,
    input  logic [RATIO_W-1:0] i_ratio,
    output logic               o_clk,
    output logic               o_tick
);

    ch_state_e          state, state_n;
    logic [RATIO_W-1:0] shadow;
    logic [RATIO_W-1:0] r_act, r_n;
    logic [RATIO_W-1:0] cnt, cnt_n;
    logic               pos, pos_n;
    logic               tick_n;
    logic               shadow_ok;
    logic               at_end;

    assign shadow_ok = 32'(shadow) >= MIN_RATIO;
    assign at_end    = (cnt == r_act - RATIO_W'(1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= CH_IDLE;
            shadow <= '0;
            r_act  <= '0;
            cnt    <= '0;
            pos    <= 1'b0;
            o_tick <= 1'b0;
        end else begin
            if (i_load) begin
                shadow <= i_ratio;
            end
            state  <= state_n;
            r_act  <= r_n;
            cnt    <= cnt_n;
            pos    <= pos_n;
            o_tick <= tick_n;
        end
    end

    // The boundary decision reads the registered shadow, so a load in the
    // same cycle only takes effect at the following boundary.
    always_comb begin
        state_n = state;
        r_n     = r_act;
        cnt_n   = cnt;
        pos_n   = 1'b0;
        tick_n  = 1'b0;
        unique case (state)
            CH_IDLE: begin
                if (i_en && shadow_ok) begin
                    state_n = CH_RUN;
                    r_n     = shadow;
                    cnt_n   = '0;
                    pos_n   = 1'b1;
                    tick_n  = 1'b1;
                end
            end
            CH_RUN: begin
                if (at_end) begin
                    cnt_n = '0;
                    if (i_en && shadow_ok) begin
                        r_n    = shadow;
                        pos_n  = 1'b1;
                        tick_n = 1'b1;
                    end else begin
                        state_n = CH_IDLE;
                    end
                end else begin
                    cnt_n = cnt + RATIO_W'(1);
                    pos_n = (32'(cnt) + 1) < hi_cnt(32'(r_act));
                end
            end
            default: state_n = CH_IDLE;
        endcase
    end

`ifdef CLK_DIV_DUTY_50_EN
    logic neg;

    always_ff @(negedge i_clk) begin
        if (i_rst) begin
            neg <= 1'b0;
        end else begin
            neg <= pos;
        end
    end

    // Odd ratios: delay the rising edge by half a cycle so high time is R/2.
    assign o_clk = r_act[0] ? (pos & neg) : pos;
`else
    assign o_clk = pos;
`endif

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable integer clock divider, NUM_CH independent channels.
// Build option: CLK_DIV_DUTY_50_EN selects exact 50% duty for odd ratios.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int unsigned NUM_CH  = DEF_NUM_CH,
    parameter int unsigned RATIO_W = DEF_RATIO_W
) (
    input  logic            i_clk,
    input  logic            i_rst,
    clk_div_multi_if.slave  div
);

    logic [NUM_CH-1:0] clk_v;
    logic [NUM_CH-1:0] tick_v;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        clk_div_ch #(
            .RATIO_W (RATIO_W)
        ) u_ch (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_en    (div.i_en[c]),
            .i_load  (div.i_load[c]),
            .i_ratio (div.i_ratio[c*RATIO_W +: RATIO_W]),
            .o_clk   (clk_v[c]),
            .o_tick  (tick_v[c])
        );
    end

    assign div.o_clk  = clk_v;
    assign div.o_tick = tick_v;

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed self-checking bench for clk_div_multi (default build and CLK_DIV_DUTY_50_EN).
module tb_clk_div_multi;
    import clk_div_pkg::*;

    localparam int unsigned NCH = 4;
    localparam int unsigned RW  = 8;

    logic        clk = 1'b0;
    logic        rst;
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    clk_div_multi_if #(.NUM_CH(NCH), .RATIO_W(RW)) dif();

    clk_div_multi #(
        .NUM_CH  (NCH),
        .RATIO_W (RW)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .div   (dif)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(int unsigned ch, ratio_t r);
        dif.i_ratio[ch*RW +: RW] = r;
        dif.i_load[ch] = 1'b1;
        step();
        dif.i_load[ch] = 1'b0;
    endtask

    // Expected o_clk sampled just after the rising edge, at counter position cnt.
    function automatic logic exp_clk(int unsigned cnt, int unsigned r);
        int unsigned hi;
        hi = (r + 1) / 2;
`ifdef CLK_DIV_DUTY_50_EN
        if (r % 2 == 1) return (cnt >= 1) && (cnt < hi);
`endif
        return cnt < hi;
    endfunction

    int unsigned rt[NCH];

    initial begin
        rt[0] = 5; rt[1] = 24; rt[2] = 17; rt[3] = 36;
        rst = 1'b1;
        dif.i_en    = '0;
        dif.i_load  = '0;
        dif.i_ratio = '0;

        // Reset state
        step();
        step();
        chk("rst_clk", 32'(dif.o_clk), 32'h0);
        chk("rst_tick", 32'(dif.o_tick), 32'h0);
        rst = 1'b0;

        // Test 1: ch0 ratio 5
        load(0, 8'd5);
        chk("t1_pre_clk0", 32'(dif.o_clk[0]), 32'h0);
        dif.i_en[0] = 1'b1;
        step();
        for (int i = 0; i < 15; i++) begin
            chk($sformatf("t1_clk0_%0d", i), 32'(dif.o_clk[0]), 32'(exp_clk(i % 5, 5)));
            chk($sformatf("t1_tick0_%0d", i), 32'(dif.o_tick[0]), 32'(i % 5 == 0));
            step();
        end

        // Test 2: ch1 ratio 24, reload 6 mid-period
        load(1, 8'd24);
        dif.i_en[1] = 1'b1;
        step();
        for (int i = 0; i < 24; i++) begin
            chk($sformatf("t2_clk1_%0d", i), 32'(dif.o_clk[1]), 32'(i < 12));
            chk($sformatf("t2_tick1_%0d", i), 32'(dif.o_tick[1]), 32'(i == 0));
            if (i == 5) begin
                dif.i_ratio[1*RW +: RW] = 8'd6;
                dif.i_load[1] = 1'b1;
            end
            if (i == 6) dif.i_load[1] = 1'b0;
            step();
        end
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("t2_clk1r6_%0d", i), 32'(dif.o_clk[1]), 32'((i % 6) < 3));
            chk($sformatf("t2_tick1r6_%0d", i), 32'(dif.o_tick[1]), 32'(i % 6 == 0));
            step();
        end

        // Test 3: ch2 ratio 17, drop enable at cnt 4
        load(2, 8'd17);
        dif.i_en[2] = 1'b1;
        step();
        for (int i = 0; i < 23; i++) begin
            if (i < 17) begin
                chk($sformatf("t3_clk2_%0d", i), 32'(dif.o_clk[2]), 32'(exp_clk(i, 17)));
                chk($sformatf("t3_tick2_%0d", i), 32'(dif.o_tick[2]), 32'(i == 0));
            end else begin
                chk($sformatf("t3_clk2_stop_%0d", i), 32'(dif.o_clk[2]), 32'h0);
                chk($sformatf("t3_tick2_stop_%0d", i), 32'(dif.o_tick[2]), 32'h0);
            end
            if (i == 4) dif.i_en[2] = 1'b0;
            step();
        end

        // Test 4: illegal ratios never start; load 1 stops at boundary
        dif.i_en[3] = 1'b1;
        load(3, 8'd1);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t4_r1_clk3_%0d", k), 32'(dif.o_clk[3]), 32'h0);
            chk($sformatf("t4_r1_tick3_%0d", k), 32'(dif.o_tick[3]), 32'h0);
            step();
        end
        load(3, 8'd0);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("t4_r0_clk3_%0d", k), 32'(dif.o_clk[3]), 32'h0);
            step();
        end
        load(3, 8'd36);
        chk("t4_pre_clk3", 32'(dif.o_clk[3]), 32'h0);
        step();
        for (int i = 0; i < 36; i++) begin
            chk($sformatf("t4_clk3_%0d", i), 32'(dif.o_clk[3]), 32'(i < 18));
            chk($sformatf("t4_tick3_%0d", i), 32'(dif.o_tick[3]), 32'(i == 0));
            if (i == 10) begin
                dif.i_ratio[3*RW +: RW] = 8'd1;
                dif.i_load[3] = 1'b1;
            end
            if (i == 11) dif.i_load[3] = 1'b0;
            step();
        end
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t4_stop_clk3_%0d", k), 32'(dif.o_clk[3]), 32'h0);
            chk($sformatf("t4_stop_tick3_%0d", k), 32'(dif.o_tick[3]), 32'h0);
            step();
        end
        dif.i_en[3] = 1'b0;

        // Test 5: all channels together, then reset mid-run
        rst = 1'b1;
        dif.i_en = '0;
        step();
        rst = 1'b0;
        for (int c = 0; c < NCH; c++) dif.i_ratio[c*RW +: RW] = 8'(rt[c]);
        dif.i_load = 4'hF;
        step();
        dif.i_load = '0;
        dif.i_en = 4'hF;
        step();
        for (int i = 0; i < 8; i++) begin
            for (int c = 0; c < NCH; c++) begin
                chk($sformatf("t5_clk%0d_%0d", c, i), 32'(dif.o_clk[c]),
                    32'(exp_clk(i % rt[c], rt[c])));
                chk($sformatf("t5_tick%0d_%0d", c, i), 32'(dif.o_tick[c]),
                    32'(i % rt[c] == 0));
            end
            step();
        end
        rst = 1'b1;
        step();
        chk("t5_rst_clk", 32'(dif.o_clk), 32'h0);
        chk("t5_rst_tick", 32'(dif.o_tick), 32'h0);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("t5_norestart_clk_%0d", k), 32'(dif.o_clk), 32'h0);
            chk($sformatf("t5_norestart_tick_%0d", k), 32'(dif.o_tick), 32'h0);
        end
        load(0, 8'd5);
        chk("t5_reload_pre_clk0", 32'(dif.o_clk[0]), 32'h0);
        step();
        chk("t5_reload_clk0", 32'(dif.o_clk[0]), 32'(exp_clk(0, 5)));
        chk("t5_reload_tick0", 32'(dif.o_tick[0]), 32'h1);

`ifdef CLK_DIV_DUTY_50_EN
        // Test 6: R=5 rises half a cycle after o_tick, high for 2.5 cycles
        @(negedge clk);
        #2;
        chk("t6_rise_half", 32'(dif.o_clk[0]), 32'h1);
        step();
        chk("t6_hi_c1", 32'(dif.o_clk[0]), 32'h1);
        step();
        chk("t6_hi_c2", 32'(dif.o_clk[0]), 32'h1);
        @(negedge clk);
        #2;
        chk("t6_hi_c2_neg", 32'(dif.o_clk[0]), 32'h1);
        step();
        chk("t6_fall_c3", 32'(dif.o_clk[0]), 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
